// File: rtl/sin_phase_recover.sv
`default_nettype none
// ============================================================================
// Module : sin_phase_recover
// Brief  : Recovers the phase index of a 40-step sine stream from sample pairs
//          and tracks it sample by sample once acquired.
// Rev    : 1.0 - initial release
// ============================================================================
module sin_phase_recover #(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [4:0] s_data,
    output logic       s_ready,
    output logic       p_valid,
    output logic [5:0] p_index,
    output logic       locked,
    output logic       miss_err
);

    localparam int c_hit_w  = $clog2(LOCK_COUNT + 1);
    localparam int c_miss_w = $clog2(MISS_LIMIT + 1);
    localparam logic [c_hit_w-1:0]  c_lock_max = c_hit_w'(LOCK_COUNT);
    localparam logic [c_miss_w-1:0] c_miss_max = c_miss_w'(MISS_LIMIT);
    localparam logic [5:0]          c_last_idx = 6'd39;

    typedef enum logic [1:0] {
        WAIT_FIRST  = 2'd0,
        WAIT_SECOND = 2'd1,
        SEARCH      = 2'd2,
        TRACK       = 2'd3
    } state_t;

    function automatic logic [4:0] f_tab(input logic [5:0] idx);
        case (idx)
            6'd0:  f_tab = 5'd15;  6'd1:  f_tab = 5'd17;  6'd2:  f_tab = 5'd19;
            6'd3:  f_tab = 5'd21;  6'd4:  f_tab = 5'd23;  6'd5:  f_tab = 5'd25;
            6'd6:  f_tab = 5'd26;  6'd7:  f_tab = 5'd27;  6'd8:  f_tab = 5'd28;
            6'd9:  f_tab = 5'd29;  6'd10: f_tab = 5'd29;  6'd11: f_tab = 5'd29;
            6'd12: f_tab = 5'd28;  6'd13: f_tab = 5'd27;  6'd14: f_tab = 5'd26;
            6'd15: f_tab = 5'd25;  6'd16: f_tab = 5'd23;  6'd17: f_tab = 5'd21;
            6'd18: f_tab = 5'd19;  6'd19: f_tab = 5'd17;  6'd20: f_tab = 5'd15;
            6'd21: f_tab = 5'd12;  6'd22: f_tab = 5'd10;  6'd23: f_tab = 5'd8;
            6'd24: f_tab = 5'd6;   6'd25: f_tab = 5'd4;   6'd26: f_tab = 5'd3;
            6'd27: f_tab = 5'd2;   6'd28: f_tab = 5'd1;   6'd29: f_tab = 5'd0;
            6'd30: f_tab = 5'd0;   6'd31: f_tab = 5'd0;   6'd32: f_tab = 5'd1;
            6'd33: f_tab = 5'd2;   6'd34: f_tab = 5'd3;   6'd35: f_tab = 5'd4;
            6'd36: f_tab = 5'd6;   6'd37: f_tab = 5'd8;   6'd38: f_tab = 5'd10;
            6'd39: f_tab = 5'd12;
            default: f_tab = 5'd0;
        endcase
    endfunction

    function automatic logic [5:0] f_inc(input logic [5:0] idx);
        f_inc = (idx == c_last_idx) ? 6'd0 : idx + 6'd1;
    endfunction

    function automatic logic [5:0] f_dec(input logic [5:0] idx);
        f_dec = (idx == 6'd0) ? c_last_idx : idx - 6'd1;
    endfunction

    state_t                r_state, w_state_nxt;
    logic [4:0]            r_prev, w_prev_nxt;
    logic [4:0]            r_cur, w_cur_nxt;
    logic [5:0]            r_k, w_k_nxt;
    logic [5:0]            r_phase, w_phase_nxt;
    logic [c_hit_w-1:0]    r_hit_cnt, w_hit_cnt_nxt;
    logic [c_miss_w-1:0]   r_miss_cnt, w_miss_cnt_nxt;
    logic                  r_p_valid, w_p_valid_nxt;
    logic [5:0]            r_p_index, w_p_index_nxt;
    logic                  r_miss_err, w_miss_err_nxt;

    logic                  w_accept;
    logic                  w_search_hit;
    logic [5:0]            w_phase_inc;
    logic                  w_track_hit;
    logic [c_miss_w-1:0]   w_miss_inc;

    assign s_ready      = (r_state != SEARCH);
    assign w_accept     = s_valid && s_ready;
    assign w_search_hit = (f_tab(r_k) == r_cur) && (f_tab(f_dec(r_k)) == r_prev);
    assign w_phase_inc  = f_inc(r_phase);
    assign w_track_hit  = (f_tab(w_phase_inc) == s_data);
    assign w_miss_inc   = r_miss_cnt + c_miss_w'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev;
        w_cur_nxt      = r_cur;
        w_k_nxt        = r_k;
        w_phase_nxt    = r_phase;
        w_hit_cnt_nxt  = r_hit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
        w_p_valid_nxt  = 1'b0;
        w_p_index_nxt  = r_p_index;
        w_miss_err_nxt = 1'b0;
        case (r_state)
            WAIT_FIRST: begin
                if (w_accept) begin
                    w_prev_nxt  = s_data;
                    w_state_nxt = WAIT_SECOND;
                end
            end
            WAIT_SECOND: begin
                if (w_accept) begin
                    w_cur_nxt   = s_data;
                    w_k_nxt     = 6'd0;
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (w_search_hit) begin
                    w_phase_nxt    = r_k;
                    w_p_valid_nxt  = 1'b1;
                    w_p_index_nxt  = r_k;
                    w_hit_cnt_nxt  = c_hit_w'(1);
                    w_miss_cnt_nxt = '0;
                    w_state_nxt    = TRACK;
                end else if (r_k == c_last_idx) begin
                    w_miss_err_nxt = 1'b1;
                    w_prev_nxt     = r_cur;
                    w_state_nxt    = WAIT_SECOND;
                end else begin
                    w_k_nxt = r_k + 6'd1;
                end
            end
            TRACK: begin
                if (w_accept) begin
                    // cur follows every tracked sample so a re-search can pair
                    // the last accepted sample with the one that failed.
                    w_phase_nxt = w_phase_inc;
                    w_cur_nxt   = s_data;
                    if (w_track_hit) begin
                        w_p_valid_nxt  = 1'b1;
                        w_p_index_nxt  = w_phase_inc;
                        w_miss_cnt_nxt = '0;
                        if (r_hit_cnt != c_lock_max) begin
                            w_hit_cnt_nxt = r_hit_cnt + c_hit_w'(1);
                        end
                    end else begin
                        w_miss_err_nxt = 1'b1;
                        w_hit_cnt_nxt  = '0;
                        w_miss_cnt_nxt = w_miss_inc;
                        if (w_miss_inc == c_miss_max) begin
                            w_prev_nxt  = r_cur;
                            w_k_nxt     = 6'd0;
                            w_state_nxt = SEARCH;
                        end
                    end
                end
            end
            default: w_state_nxt = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT_FIRST;
            r_prev     <= '0;
            r_cur      <= '0;
            r_k        <= '0;
            r_phase    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_p_valid  <= 1'b0;
            r_p_index  <= '0;
            r_miss_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_cur      <= w_cur_nxt;
            r_k        <= w_k_nxt;
            r_phase    <= w_phase_nxt;
            r_hit_cnt  <= w_hit_cnt_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
            r_p_valid  <= w_p_valid_nxt;
            r_p_index  <= w_p_index_nxt;
            r_miss_err <= w_miss_err_nxt;
        end
    end

    assign p_valid  = r_p_valid;
    assign p_index  = r_p_index;
    assign miss_err = r_miss_err;
    assign locked   = (r_state == TRACK) && (r_hit_cnt >= c_lock_max);

endmodule
`default_nettype wire

// File: tb/tb_sin_phase_recover.sv
`default_nettype none
// ============================================================================
// Module : tb_sin_phase_recover
// Brief  : Directed self-checking bench for sin_phase_recover.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sin_phase_recover;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [4:0] s_data = 5'd0;
    logic       s_ready;
    logic       p_valid;
    logic [5:0] p_index;
    logic       locked;
    logic       miss_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_both  = 0;
    int tab[40] = '{15,17,19,21,23,25,26,27,28,29,29,29,28,27,26,25,23,21,19,17,
                    15,12,10,8,6,4,3,2,1,0,0,0,1,2,3,4,6,8,10,12};
    int n_pv, n_me, idx;

    always #5 clk = ~clk;

    sin_phase_recover #(.LOCK_COUNT(4), .MISS_LIMIT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .p_valid  (p_valid),
        .p_index  (p_index),
        .locked   (locked),
        .miss_err (miss_err)
    );

    always @(posedge clk) begin
        #1;
        if (p_valid && miss_err) n_both++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic send(input int d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 5'(d);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_evt(input int limit, output int o_pv, output int o_me, output int o_idx);
        o_pv  = 0;
        o_me  = 0;
        o_idx = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (p_valid) begin
                o_pv  = i;
                o_idx = int'(p_index);
            end
            if (miss_err) o_me = i;
            if (p_valid || miss_err) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_p_valid", int'(p_valid), 0);
        chk("rst_miss_err", int'(miss_err), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_p_index", int'(p_index), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquisition 15,17 -> k=1, then track to lock
        send(15);
        chk("w2_s_ready", int'(s_ready), 1);
        send(17);
        chk("search_s_ready", int'(s_ready), 0);
        wait_evt(60, n_pv, n_me, idx);
        chk("acq_latency", n_pv, 2);
        chk("acq_index", idx, 1);
        chk("acq_no_miss", n_me, 0);
        chk("acq_locked", int'(locked), 0);
        send(19);
        chk("t19_pv", int'(p_valid), 1);
        chk("t19_idx", int'(p_index), 2);
        chk("t19_locked", int'(locked), 0);
        send(21);
        chk("t21_idx", int'(p_index), 3);
        chk("t21_locked", int'(locked), 0);
        send(23);
        chk("t23_idx", int'(p_index), 4);
        chk("t23_locked", int'(locked), 1);
        @(posedge clk);
        #1;
        chk("pv_one_cycle", int'(p_valid), 0);
        chk("idle_locked", int'(locked), 1);

        // Track through to phase 39, then wrap to 0
        for (int i = 5; i < 40; i++) begin
            send(tab[i]);
            chk("track_pv", int'(p_valid), 1);
            chk("track_idx", int'(p_index), i);
        end
        chk("p39_locked", int'(locked), 1);
        send(15);
        chk("wrap_pv", int'(p_valid), 1);
        chk("wrap_idx", int'(p_index), 0);
        chk("wrap_locked", int'(locked), 1);

        // Miss limit from phase 5
        for (int i = 1; i <= 5; i++) send(tab[i]);
        chk("p5_idx", int'(p_index), 5);
        chk("p5_locked", int'(locked), 1);
        send(0);
        chk("miss1_err", int'(miss_err), 1);
        chk("miss1_pv", int'(p_valid), 0);
        chk("miss1_locked", int'(locked), 0);
        chk("miss1_ready", int'(s_ready), 1);
        send(0);
        chk("miss2_err", int'(miss_err), 1);
        chk("miss2_ready", int'(s_ready), 0);
        wait_evt(60, n_pv, n_me, idx);
        chk("reacq_latency", n_pv, 31);
        chk("reacq_index", idx, 30);
        chk("reacq_no_miss", n_me, 0);

        // Asynchronous reset mid-TRACK clears p_index before any edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_track_idx", int'(p_index), 0);
        chk("arst_track_locked", int'(locked), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ambiguous pair 29,29 -> lowest k=10
        send(29);
        send(29);
        wait_evt(60, n_pv, n_me, idx);
        chk("amb_latency", n_pv, 11);
        chk("amb_index", idx, 10);

        // No match: 30,30 then 15
        do_reset();
        send(30);
        send(30);
        wait_evt(60, n_pv, n_me, idx);
        chk("nomatch_err_cycle", n_me, 40);
        chk("nomatch_pv", n_pv, 0);
        chk("nomatch_ready", int'(s_ready), 1);
        send(15);
        chk("nomatch2_ready", int'(s_ready), 0);
        wait_evt(60, n_pv, n_me, idx);
        chk("nomatch2_err_cycle", n_me, 40);
        chk("nomatch2_pv", n_pv, 0);

        // Reset at SEARCH cycle 5 while scanning (29,29)
        do_reset();
        send(29);
        send(29);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_search_ready", int'(s_ready), 1);
        chk("arst_search_pv", int'(p_valid), 0);
        chk("arst_search_err", int'(miss_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_evt(20, n_pv, n_me, idx);
        chk("post_rst_pv", n_pv, 0);
        chk("post_rst_err", n_me, 0);
        chk("post_rst_ready", int'(s_ready), 1);
        send(29);
        send(29);
        wait_evt(60, n_pv, n_me, idx);
        chk("restart_latency", n_pv, 11);
        chk("restart_index", idx, 10);

        chk("pv_err_exclusive", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
